bit_serializer: RTL and testbench
=================================

# bit_serializer

Parallel-to-serial front end for the single-bit sequence-detector FSM. Accepts WIDTH-bit words over a valid/ready handshake and emits them MSB-first, one bit per clock, on a registered serial output. That output drives the detector's `Input` directly. A one-word holding buffer lets consecutive words stream with no idle gap between them.

## Interface
- `WIDTH`, default 8: word width in bits, ≥2.
- `IDLE_BIT`, default 0: value driven on `out_bit` whenever no word is being shifted.
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `in_data` input WIDTH: word to serialize; sampled on accept.
- `in_valid` input 1: `in_data` is valid.
- `in_ready` output 1: holding buffer is empty. Accept occurs on a rising edge with `in_valid && in_ready`.
- `out_bit` output 1: current serial bit; registered. Connects to the detector `Input`.
- `out_valid` output 1: `out_bit` carries word data this cycle.
- `out_first` output 1: high during the cycle that `out_bit` carries a word's MSB.
- `busy` output 1: shifter active or holding buffer full.

## Operation
- State:
  - shift register `sh[WIDTH-1:0]`
  - bit counter `cnt` of width clog2(WIDTH)
  - `active` flag
  - holding register `hold[WIDTH-1:0]` with flag `hold_full`
- Outputs:
  - `out_bit` = `active ? sh[WIDTH-1] : IDLE_BIT`
  - `out_valid` = `active`
  - `out_first` = `active && cnt==0`
  - `in_ready` = `!hold_full`
  - `busy` = `active || hold_full`
- `last` = `active && cnt==WIDTH-1`. `slot` = `!active || last`: the shifter can take a new word at this edge.
- Shifter source priority at an edge with `slot`:
  1. `hold`, if `hold_full`. Then `hold_full` clears.
  2. Otherwise `in_data`, if accepted this edge. The word bypasses `hold`.
  3. Otherwise `active` clears, and `sh` and `cnt` hold their values.
- On load: `sh` ← source, `cnt` ← 0, `active` ← 1.
- On a non-`last` active edge: `sh` ← `sh << 1`, `cnt` ← `cnt+1`.
- An accepted word that did not go straight to the shifter is written to `hold`, and `hold_full` sets.
- Simultaneous events:
  - `hold_full`, `last`, and `in_valid` together: no accept, because `in_ready`=0. `hold` moves to the shifter. `in_ready` rises the next cycle.
  - `slot` with `hold` empty and an accept: the word loads the shifter directly. `hold` stays empty and `in_ready` stays 1.
  - Not `slot` with `hold` empty and an accept: the word goes to `hold`. `in_ready`=0 next cycle.
- `in_data` and `in_valid` are ignored when `in_ready`=0. The upstream must hold them stable until accept.
- Reset (`rst_n`=0), at any time including mid-word:
  - Immediately clears `active`, `hold_full`, `cnt`, `sh`, and `hold`.
  - Outputs become: `out_bit`=`IDLE_BIT`, `out_valid`=0, `out_first`=0, `in_ready`=1, `busy`=0.
  - The partial word is discarded and is not resumed.

## Timing
- Latency: a word accepted at edge N into an idle block gives its MSB on `out_bit` during cycle N→N+1. Its LSB appears in cycle N+WIDTH-1→N+WIDTH.
- Throughput: one bit per clock. A continuous supply gives gapless words, with `out_valid` high for k·WIDTH consecutive cycles.
- `in_ready` is registered state only and has no combinational path from `in_valid`.
- First accepted edge after `rst_n` deasserts: the first rising edge with `rst_n`=1.
- `out_bit` changes only on rising `clk` or on asynchronous reset. It is stable for the detector's sampling at the next edge.

## Test plan
- **Reset:** hold `rst_n`=0 for 2 cycles, then release → `out_bit`=0, `out_valid`=0, `in_ready`=1, `busy`=0 until the first accept.
- **Single word:** WIDTH=8, send 8'hA5 once into an idle block → over 8 cycles `out_bit`=1,0,1,0,0,1,0,1. `out_valid`=1 for exactly those 8 cycles. `out_first` is high only in the first. Then idle (0, 0).
- **Back-to-back:** `in_valid` held with 8'hF0, then 8'h0F → 16 contiguous valid bits 11110000 00001111, with `out_first` at bits 0 and 8. `in_ready` drops for one word time, then recovers.
- **Backpressure:** present 8'hFF, 8'h81, 8'h3C continuously → `in_ready`=0 while `hold` is full, and the third word is accepted only after `hold` drains at the first word's LSB. The output stream is exactly the three words with no gaps, repeats, or loss.
- **Reset mid-word:** pulse `rst_n` low asynchronously (not on an edge) after 3 bits of 8'hC3, with a word held → outputs go to idle at once without waiting for `clk`. After release, a new 8'h55 is emitted in full with no remnants of 8'hC3.
- **End to end with the detector FSM:** `out_bit` → `Input`, send 8'h55 → the detector sees the alternating stream 0,1,0,1,… and its `Output` matches the detector's golden response for that bit sequence.

Source files
------------

// File: rtl/bit_serializer_if.sv
// Handshake/stream bundle for bit_serializer.
//   in_data   : word to serialize (sampled on accept)
//   in_valid  : in_data is valid
//   in_ready  : holding buffer empty; accept = in_valid && in_ready at rising clk
//   out_bit   : current serial bit (from flops only)
//   out_valid : out_bit carries word data
//   out_first : out_bit carries a word's MSB
//   busy      : shifter active or holding buffer full
// master = upstream/observer side, slave = serializer side.
interface bit_serializer_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             out_bit;
  logic             out_valid;
  logic             out_first;
  logic             busy;

  modport master (
    output in_data, in_valid,
    input  in_ready, out_bit, out_valid, out_first, busy
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, out_bit, out_valid, out_first, busy
  );
endinterface

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: accepts WIDTH-bit words over valid/ready and
// emits them MSB-first, one bit per clock. A one-word holding buffer lets
// consecutive words stream without an idle cycle between them.
// Ports:
//   clk   : clock, all state updates on rising edge
//   rst_n : asynchronous active-low reset
//   bus   : bit_serializer_if.slave (in_data/in_valid/in_ready,
//           out_bit/out_valid/out_first/busy)
module bit_serializer #(
  parameter int unsigned WIDTH    = 8,
  parameter bit          IDLE_BIT = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  bit_serializer_if.slave   bus
);

  localparam int unsigned    CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic {
    S_IDLE,
    S_SHIFT
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_sh,    w_sh_nxt;
  logic [CW-1:0]    r_cnt,   w_cnt_nxt;
  logic [WIDTH-1:0] r_hold,  w_hold_nxt;
  logic             r_hold_full, w_hold_full_nxt;

  logic w_active;
  logic w_last;
  logic w_slot;
  logic w_accept;

  assign w_active = (r_state == S_SHIFT);
  assign w_last   = w_active && (r_cnt == LAST_CNT);
  // Shifter can take a new word at this edge.
  assign w_slot   = !w_active || w_last;
  assign w_accept = bus.in_valid && !r_hold_full;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_sh        <= '0;
      r_cnt       <= '0;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_sh        <= w_sh_nxt;
      r_cnt       <= w_cnt_nxt;
      r_hold      <= w_hold_nxt;
      r_hold_full <= w_hold_full_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt     = r_state;
    w_sh_nxt        = r_sh;
    w_cnt_nxt       = r_cnt;
    w_hold_nxt      = r_hold;
    w_hold_full_nxt = r_hold_full;

    if (w_slot) begin
      if (r_hold_full) begin
        // Held word has priority; no accept is possible while hold is full.
        w_sh_nxt        = r_hold;
        w_cnt_nxt       = '0;
        w_state_nxt     = S_SHIFT;
        w_hold_full_nxt = 1'b0;
      end else if (w_accept) begin
        // Bypass: word goes straight into the shifter, hold stays empty.
        w_sh_nxt    = bus.in_data;
        w_cnt_nxt   = '0;
        w_state_nxt = S_SHIFT;
      end else begin
        // Nothing to load: go idle, sh/cnt keep their values.
        w_state_nxt = S_IDLE;
      end
    end else begin
      w_sh_nxt  = {r_sh[WIDTH-2:0], 1'b0};
      w_cnt_nxt = r_cnt + CW'(1);
      if (w_accept) begin
        w_hold_nxt      = bus.in_data;
        w_hold_full_nxt = 1'b1;
      end
    end
  end

  // Output logic (depends on registered state only)
  always_comb begin
    bus.out_valid = w_active;
    bus.out_bit   = w_active ? r_sh[WIDTH-1] : IDLE_BIT;
    bus.out_first = w_active && (r_cnt == '0);
    bus.in_ready  = !r_hold_full;
    bus.busy      = w_active || r_hold_full;
  end

endmodule

// File: tb/tb_bit_serializer.sv
// Self-checking bench for bit_serializer (WIDTH=8, IDLE_BIT=0).
// Reference model: a queue of bits still to be emitted. Every accepted word
// appends its WIDTH bits MSB-first; every clock edge retires the bit shown
// during the previous cycle. All expected outputs derive from the queue depth.
module tb_bit_serializer;

  localparam int unsigned W    = 8;
  localparam bit          IDLE = 1'b0;

  logic clk;
  logic rst_n;

  bit_serializer_if #(.WIDTH(W)) bus ();

  bit_serializer #(.WIDTH(W), .IDLE_BIT(IDLE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
  endtask

  // ---------------- reference model ----------------
  bit mq[$];

  function automatic bit model_ready();
    return mq.size() <= W;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
    end else begin
      bit acc;
      acc = bus.in_valid && model_ready();
      if (mq.size() > 0) void'(mq.pop_front());
      if (acc)
        for (int i = W - 1; i >= 0; i--) mq.push_back(bus.in_data[i]);
    end
  end

  // ---------------- capture + per-cycle compare ----------------
  bit dut_q[$];
  bit mdl_q[$];
  int n_first;
  int n_runs;
  bit prev_v;

  task automatic clear_capture();
    dut_q.delete();
    mdl_q.delete();
    n_first = 0;
    n_runs  = 0;
    prev_v  = 1'b0;
  endtask

  always @(negedge clk) begin
    logic [4:0] act, exp;
    bit ev, eb, ef;
    ev  = (mq.size() > 0);
    eb  = ev ? mq[0] : IDLE;
    ef  = ev && (mq.size() % W == 0);
    exp = {model_ready(), ev, ev, ef, eb};
    act = {bus.in_ready, bus.busy, bus.out_valid, bus.out_first, bus.out_bit};
    chk("cycle_outputs{rdy,busy,vld,first,bit}", {27'd0, act}, {27'd0, exp});
    if (bus.out_valid) dut_q.push_back(bus.out_bit);
    if (ev) mdl_q.push_back(eb);
    if (bus.out_first) n_first++;
    if (bus.out_valid && !prev_v) n_runs++;
    prev_v = bus.out_valid;
  end

  function automatic logic [31:0] pack(input bit q[$]);
    logic [31:0] r = '0;
    foreach (q[i]) r = {r[30:0], q[i]};
    return r;
  endfunction

  // ---------------- drivers ----------------
  task automatic send(input logic [W-1:0] w);
    int n = 0;
    bit rdy;
    bus.in_valid = 1'b1;
    bus.in_data  = w;
    do begin
      rdy = model_ready();
      @(posedge clk);
      #1;
      n++;
    end while (!rdy && n < 100);
    chk("send_accepted", {31'd0, rdy}, 32'd1);
  endtask

  task automatic drain();
    int n = 0;
    bus.in_valid = 1'b0;
    while ((bus.busy || mq.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_in_time", {31'd0, (n < 200)}, 32'd1);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_stream(input string name, input logic [31:0] exp_bits,
                              input int exp_len, input int exp_first);
    chk({name, "_dut_bits"},  pack(dut_q), exp_bits);
    chk({name, "_model_bits"}, pack(mdl_q), exp_bits);
    chk({name, "_len"},   32'(dut_q.size()), 32'(exp_len));
    chk({name, "_firsts"}, 32'(n_first), 32'(exp_first));
    chk({name, "_runs"},  32'(n_runs), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // Reset/idle state
    @(negedge clk);
    chk("reset_idle", {27'd0, bus.in_ready, bus.busy, bus.out_valid, bus.out_first, bus.out_bit},
        32'b10000);
    repeat (2) @(negedge clk);

    // Single word: MSB visible in the cycle right after the accept edge
    clear_capture();
    send(8'hA5);
    chk("single_latency{vld,first,bit}", {29'd0, bus.out_valid, bus.out_first, bus.out_bit},
        32'b111);
    drain();
    check_stream("single", 32'h0000_00A5, 8, 1);

    // Back-to-back: second word lands in hold
    clear_capture();
    send(8'hF0);
    send(8'h0F);
    chk("b2b_hold_full_ready", {31'd0, bus.in_ready}, 32'd0);
    drain();
    check_stream("b2b", 32'h0000_F00F, 16, 2);

    // Backpressure: third word waits until hold drains
    clear_capture();
    send(8'hFF);
    send(8'h81);
    chk("bp_ready_low", {31'd0, bus.in_ready}, 32'd0);
    send(8'h3C);
    drain();
    check_stream("bp", 32'h00FF_813C, 24, 3);

    // Asynchronous reset mid-word with a word held
    clear_capture();
    send(8'hC3);
    send(8'h99);
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_outputs", {27'd0, bus.in_ready, bus.busy, bus.out_valid, bus.out_first,
        bus.out_bit}, 32'b10000);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
    clear_capture();
    send(8'h55);
    drain();
    check_stream("post_rst", 32'h0000_0055, 8, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
